// File: rtl/life_pkg.sv
// Shared definitions for the Life board editing path: button bit positions,
// toggle FSM states and default grid geometry.
package life_pkg;

  localparam int NUM_BTNS = 5;
  localparam int BTN_C    = 4;
  localparam int BTN_U    = 3;
  localparam int BTN_L    = 2;
  localparam int BTN_R    = 1;
  localparam int BTN_D    = 0;

  localparam int DEFAULT_LINE_WIDTH = 8;
  localparam int DEFAULT_ADDR_SIZE  = 3;
  localparam int CURSOR_X_W         = $clog2(DEFAULT_LINE_WIDTH);
  localparam int CURSOR_Y_W         = DEFAULT_ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } editor_state_t;

endpackage

// File: rtl/debouncer.sv
// Single push-button conditioner: 2-FF synchroniser, stability counter and
// a one-cycle pulse on each accepted press (release produces nothing).
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_in,
  output logic level_out,
  output logic press_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             press_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw_in};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // Difference survived the whole window: accept the new level.
        cnt_reg   <= '0;
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level_out = level_reg;
  assign press_out = press_reg;

endmodule

// File: rtl/cell_editor.sv
// Button-driven edit cursor with a read-modify-write cell toggle on the
// double buffer's logic-side port.
module cell_editor
  import life_pkg::*;
#(
  parameter int LINE_WIDTH      = DEFAULT_LINE_WIDTH,
  parameter int ADDR_SIZE       = DEFAULT_ADDR_SIZE,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM_BTNS-1:0]           btn_in,
  input  logic                          edit_en_in,
  output logic [ADDR_SIZE-1:0]          addr_r_out,
  input  logic [LINE_WIDTH-1:0]         data_r_in,
  output logic [ADDR_SIZE-1:0]          addr_w_out,
  output logic [LINE_WIDTH-1:0]         data_w_out,
  output logic                          we_out,
  output logic [$clog2(LINE_WIDTH)-1:0] cursor_x_out,
  output logic [ADDR_SIZE-1:0]          cursor_y_out,
  output logic                          busy_out
);

  localparam int X_W = $clog2(LINE_WIDTH);
  localparam logic [X_W-1:0]       X_MAX = X_W'(LINE_WIDTH - 1);
  localparam logic [ADDR_SIZE-1:0] Y_MAX = '1;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_reg <= '0;
    else           rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] btn_level_unused;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n),
        .raw_in   (btn_in[gi]),
        .level_out(btn_level_unused[gi]),
        .press_out(press[gi])
      );
    end
  endgenerate

  logic [X_W-1:0]       x_reg;
  logic [ADDR_SIZE-1:0] y_reg;

  // Opposing presses in the same cycle cancel; orthogonal ones both apply.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      if (press[BTN_L] && !press[BTN_R])      x_reg <= (x_reg == '0)    ? X_MAX : x_reg - 1'b1;
      else if (press[BTN_R] && !press[BTN_L]) x_reg <= (x_reg == X_MAX) ? '0    : x_reg + 1'b1;
      if (press[BTN_U] && !press[BTN_D])      y_reg <= (y_reg == '0)    ? Y_MAX : y_reg - 1'b1;
      else if (press[BTN_D] && !press[BTN_U]) y_reg <= (y_reg == Y_MAX) ? '0    : y_reg + 1'b1;
    end
  end

  editor_state_t state_reg, state_next;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (press[BTN_C] && edit_en_in) state_next = READ;
      READ:    state_next = edit_en_in ? WAIT  : IDLE;
      WAIT:    state_next = edit_en_in ? WRITE : IDLE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [X_W-1:0]        tx_reg;
  logic [ADDR_SIZE-1:0]  ty_reg;
  logic [ADDR_SIZE-1:0]  addr_r_reg;
  logic [ADDR_SIZE-1:0]  addr_w_reg;
  logic [LINE_WIDTH-1:0] data_w_reg;
  logic                  we_reg;
  logic [LINE_WIDTH-1:0] bit_mask;

  assign bit_mask = LINE_WIDTH'(1) << tx_reg;

  // Target is latched on entry so cursor moves mid-toggle are harmless.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg     <= '0;
      ty_reg     <= '0;
      addr_r_reg <= '0;
      addr_w_reg <= '0;
      data_w_reg <= '0;
      we_reg     <= 1'b0;
    end else begin
      we_reg <= (state_next == WRITE);
      if (state_reg == IDLE && state_next == READ) begin
        tx_reg     <= x_reg;
        ty_reg     <= y_reg;
        addr_r_reg <= y_reg;
      end
      if (state_reg == WAIT && state_next == WRITE) begin
        addr_w_reg <= ty_reg;
        data_w_reg <= data_r_in ^ bit_mask;
      end
    end
  end

  assign addr_r_out   = addr_r_reg;
  assign addr_w_out   = addr_w_reg;
  assign data_w_out   = data_w_reg;
  assign we_out       = we_reg;
  assign cursor_x_out = x_reg;
  assign cursor_y_out = y_reg;
  assign busy_out     = (state_reg != IDLE);

endmodule

// File: tb/tb_cell_editor.sv
// Randomised bench for cell_editor: a behavioural grid/cursor model predicts
// cursor position and buffer writes for each button transaction.
module tb_cell_editor;
  import life_pkg::*;

  localparam int LW = 8;
  localparam int AS = 3;
  localparam int DB = 4;
  localparam int ROWS = 1 << AS;

  localparam logic [4:0] M_C = 5'b10000;
  localparam logic [4:0] M_U = 5'b01000;
  localparam logic [4:0] M_L = 5'b00100;
  localparam logic [4:0] M_R = 5'b00010;
  localparam logic [4:0] M_D = 5'b00001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    btn;
  logic          edit_en;
  logic [AS-1:0] addr_r, addr_w, cy;
  logic [LW-1:0] data_r, data_w;
  logic          we, busy;
  logic [2:0]    cx;

  always #5 clk = ~clk;

  cell_editor #(.LINE_WIDTH(LW), .ADDR_SIZE(AS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .btn_in      (btn),
    .edit_en_in  (edit_en),
    .addr_r_out  (addr_r),
    .data_r_in   (data_r),
    .addr_w_out  (addr_w),
    .data_w_out  (data_w),
    .we_out      (we),
    .cursor_x_out(cx),
    .cursor_y_out(cy),
    .busy_out    (busy)
  );

  // Buffer stand-in: one-cycle read latency, write on strobe.
  logic [LW-1:0] ram     [ROWS];
  logic [LW-1:0] ref_mem [ROWS];
  logic          load = 1'b0;

  always @(posedge clk) begin
    data_r <= ram[addr_r];
    if (load) begin
      for (int i = 0; i < ROWS; i++) ram[i] <= ref_mem[i];
    end else if (we) begin
      ram[addr_w] <= data_w;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            wr_count = 0;
  int            busy_cnt = 0;
  logic [AS-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  int            wr_cyc = 0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_count++;
      wr_addr = addr_w;
      wr_data = data_w;
      wr_cyc  = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
  end

  int total = 0;
  int bad   = 0;
  int mx = 0;
  int my = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full press/release with the model's prediction checked afterwards.
  task automatic do_press(input logic [4:0] mask, input logic en);
    int            w0;
    bit            exp_wr;
    logic [AS-1:0] ea;
    logic [LW-1:0] ed;
    w0 = wr_count;
    exp_wr = mask[BTN_C] && en;
    ea = AS'(my);
    ed = ref_mem[my] ^ (LW'(1) << mx);
    if (exp_wr) ref_mem[my] = ed;
    if (mask[BTN_L] && !mask[BTN_R]) mx = (mx + LW - 1) % LW;
    if (mask[BTN_R] && !mask[BTN_L]) mx = (mx + 1) % LW;
    if (mask[BTN_U] && !mask[BTN_D]) my = (my + ROWS - 1) % ROWS;
    if (mask[BTN_D] && !mask[BTN_U]) my = (my + 1) % ROWS;
    edit_en = en;
    btn = mask;
    tick(12);
    btn = 5'b0;
    tick(10);
    $display("press btn=%b en=%b cursor=(%0d,%0d) writes=%0d", mask, en, cx, cy, wr_count - w0);
    check("cursor_x", cx, mx);
    check("cursor_y", cy, my);
    check("write_count", wr_count - w0, exp_wr ? 1 : 0);
    if (exp_wr) begin
      check("write_addr", wr_addr, ea);
      check("write_data", wr_data, ed);
    end
  endtask

  initial begin
    int w0, b0, t0;
    rst_n = 1'b0;
    btn = 5'b0;
    edit_en = 1'b0;
    for (int i = 0; i < ROWS; i++) ref_mem[i] = LW'($urandom);
    ref_mem[2] = 8'h0F;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2);
    check("rst_cursor_x", cx, 0);
    check("rst_cursor_y", cy, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_r", addr_r, 0);
    check("rst_addr_w", addr_w, 0);
    check("rst_data_w", data_w, 0);
    rst_n = 1'b1;
    tick(4);

    // Short glitch must be filtered out.
    btn = M_R;
    tick(3);
    btn = 5'b0;
    tick(10);
    check("glitch_x", cx, 0);

    // Held press: cursor moves on the 7th edge after the raw edge, once.
    btn = M_R;
    tick(6);
    check("latency_before", cx, 0);
    tick(1);
    check("latency_at", cx, 1);
    tick(3);
    btn = 5'b0;
    tick(10);
    check("single_step", cx, 1);
    mx = 1;

    do_press(M_L, 1'b1);
    do_press(M_L, 1'b1);
    check("wrap_left", cx, 7);
    do_press(M_U, 1'b0);
    check("wrap_up", cy, 7);
    do_press(M_D, 1'b0);
    check("wrap_down", cy, 0);

    // Walk to (3,2) for the directed toggle.
    repeat (4) do_press(M_R, 1'b1);
    repeat (2) do_press(M_D, 1'b1);

    w0 = wr_count;
    edit_en = 1'b1;
    btn = M_C;
    t0 = cyc;
    tick(7);
    check("toggle_addr_r", addr_r, 2);
    check("toggle_busy", busy, 1);
    tick(2);
    check("toggle_we", we, 1);
    tick(3);
    btn = 5'b0;
    tick(10);
    check("toggle_count", wr_count - w0, 1);
    check("toggle_addr_w", wr_addr, 2);
    check("toggle_data", wr_data, 8'h07);
    check("toggle_latency", wr_cyc - t0, 9);
    ref_mem[2] = 8'h07;
    do_press(M_C, 1'b1);
    check("toggle_back", wr_data, 8'h0F);

    // Gated press: nothing happens.
    b0 = busy_cnt;
    do_press(M_C, 1'b0);
    check("gated_busy", busy_cnt - b0, 0);

    // Drop edit enable while waiting on read data.
    w0 = wr_count;
    edit_en = 1'b1;
    btn = M_C;
    tick(8);
    check("abort_in_wait", busy, 1);
    edit_en = 1'b0;
    tick(1);
    check("abort_idle", busy, 0);
    btn = 5'b0;
    tick(10);
    check("abort_no_write", wr_count - w0, 0);

    do_press(M_L | M_R, 1'b1);
    do_press(M_U | M_D | M_R, 1'b1);

    repeat (40) do_press(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    for (int i = 0; i < ROWS; i++) check("ram_contents", ram[i], ref_mem[i]);

    // Reset while the write strobe is up.
    do_press(M_R, 1'b0);
    w0 = wr_count;
    edit_en = 1'b1;
    btn = M_C;
    tick(9);
    check("pre_reset_we", we, 1);
    #2;
    rst_n = 1'b0;
    btn = 5'b0;
    #1;
    check("reset_we_async", we, 0);
    check("reset_busy_async", busy, 0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("post_reset_x", cx, 0);
    check("post_reset_y", cy, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_no_write", wr_count - w0, 0);
    check("post_reset_ram", ram[my], ref_mem[my]);
    mx = 0;
    my = 0;
    do_press(M_R | M_D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
